// File: rtl/riscv_core_mul_iter.sv
// Iterative radix-2 shift-add multiplier front end: sign/magnitude split, then unsigned magnitude product.
// Latency XLEN (or XLEN/2 in word mode) cycles after accept; result held in DONE until consumed; flush kills.
module riscv_core_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mul_in_valid,
  output logic              o_mul_in_ready,
  input  logic [XLEN-1:0]   i_mul_in_srcA,
  input  logic [XLEN-1:0]   i_mul_in_srcB,
  input  logic [1:0]        i_mul_in_control,
  input  logic              i_mul_in_isword,
  input  logic              i_mul_in_flush,
  output logic              o_mul_in_valid,
  input  logic              i_mul_in_ready,
  output logic [2*XLEN-1:0] o_mul_in_product,
  output logic              o_mul_in_srcA_Dsign,
  output logic              o_mul_in_srcB_Dsign,
  output logic              o_mul_in_srcA_Wsign,
  output logic              o_mul_in_srcB_Wsign,
  output logic [1:0]        o_mul_in_control,
  output logic              o_mul_in_isword
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     cnt;
  logic              a_dsign, b_dsign, a_wsign, b_wsign;
  logic [1:0]        ctrl_q;
  logic              isword_q;

  logic              accept;
  logic              signed_a, signed_b;
  logic              a_dsign_in, b_dsign_in, a_wsign_in, b_wsign_in;
  logic [HALF-1:0]   a_low, b_low, a_mag_w, b_mag_w;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [CW-1:0]     n_iter;

  // Operand decode: only meaningful in the accept cycle.
  always_comb begin
    signed_a   = (i_mul_in_control != 2'b11);
    signed_b   = !i_mul_in_control[1];
    a_dsign_in = !i_mul_in_isword & signed_a & i_mul_in_srcA[XLEN-1];
    b_dsign_in = !i_mul_in_isword & signed_b & i_mul_in_srcB[XLEN-1];
    a_wsign_in = i_mul_in_isword & i_mul_in_srcA[HALF-1];
    b_wsign_in = i_mul_in_isword & i_mul_in_srcB[HALF-1];
    a_low      = i_mul_in_srcA[HALF-1:0];
    b_low      = i_mul_in_srcB[HALF-1:0];
    a_mag_w    = a_wsign_in ? -a_low : a_low;
    b_mag_w    = b_wsign_in ? -b_low : b_low;
    if (i_mul_in_isword) begin
      a_mag  = {{HALF{1'b0}}, a_mag_w};
      b_mag  = {{HALF{1'b0}}, b_mag_w};
      n_iter = CW'(HALF);
    end else begin
      a_mag  = a_dsign_in ? -i_mul_in_srcA : i_mul_in_srcA;
      b_mag  = b_dsign_in ? -i_mul_in_srcB : i_mul_in_srcB;
      n_iter = CW'(XLEN);
    end
  end

  assign o_mul_in_ready = (state == IDLE) | ((state == DONE) & i_mul_in_ready);
  assign accept         = i_mul_in_valid & o_mul_in_ready & !i_mul_in_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: begin
        if (accept)              state_nxt = BUSY;
        else if (i_mul_in_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_mul_in_flush) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      a_dsign  <= 1'b0;
      b_dsign  <= 1'b0;
      a_wsign  <= 1'b0;
      b_wsign  <= 1'b0;
      ctrl_q   <= 2'b00;
      isword_q <= 1'b0;
    end else if (i_mul_in_flush) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      a_dsign  <= 1'b0;
      b_dsign  <= 1'b0;
      a_wsign  <= 1'b0;
      b_wsign  <= 1'b0;
      ctrl_q   <= 2'b00;
      isword_q <= 1'b0;
    end else if (accept) begin
      acc      <= '0;
      mcand    <= {{XLEN{1'b0}}, a_mag};
      mplier   <= b_mag;
      cnt      <= n_iter;
      a_dsign  <= a_dsign_in;
      b_dsign  <= b_dsign_in;
      a_wsign  <= a_wsign_in;
      b_wsign  <= b_wsign_in;
      ctrl_q   <= i_mul_in_control;
      isword_q <= i_mul_in_isword;
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  // Partial sums stay hidden until the full product is ready.
  assign o_mul_in_valid      = (state == DONE);
  assign o_mul_in_product    = (state == DONE) ? acc : '0;
  assign o_mul_in_srcA_Dsign = a_dsign;
  assign o_mul_in_srcB_Dsign = b_dsign;
  assign o_mul_in_srcA_Wsign = a_wsign;
  assign o_mul_in_srcB_Wsign = b_wsign;
  assign o_mul_in_control    = ctrl_q;
  assign o_mul_in_isword     = isword_q;

endmodule
